mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified RAM port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access through a small FSM that handles the fixed RAM read latency.
- Returns per-requester ready pulses.
- Raises per-stage stall requests that feed the pipeline stall/flush controller alongside the ID load-use stall.

Parameters:
- RAM_LATENCY, 1: cycles from ram_ce pulse to valid ram_rdata; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF read request; held until if_ready
- if_addr  in  32  IF fetch address
- flush_if  in  1  IF stage flushed (branch taken); kills any in-flight IF access
- if_ready  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched instruction
- mem_req  in  1  MEM request; held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_wmask  in  4  byte enables for a store
- mem_ready  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  load data; 0 after a store
- ram_ce  out  1  one-cycle access strobe
- ram_we  out  1  write strobe, coincident with ram_ce
- ram_addr  out  32  RAM address, held from ISSUE through WAIT
- ram_wdata  out  32  RAM write data
- ram_wmask  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data
- stall_req_if  out  1  if_req & ~if_ready
- stall_req_mem  out  1  mem_req & ~mem_ready

Behaviour:
- Reset, asynchronous and effective immediately, including mid-transaction:
  - state = IDLE
  - all registered outputs = 0
  - latency counter, owner flag and kill flag cleared
  - the in-flight RAM access is abandoned.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If mem_req, grant MEM; else if if_req && !flush_if, grant IF.
  - On a grant: latch owner, addr, we, wdata, wmask; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): ram_ce = 1, ram_we = latched we; counter loaded with RAM_LATENCY; go to WAIT.
- WAIT (RAM_LATENCY cycles): counter decrements; on the last cycle, capture ram_rdata (loads/fetches) and go to RESP.
- RESP (1 cycle):
  - Assert the owner's ready with captured data.
  - IF ready is suppressed if the kill flag is set.
  - Go to IDLE.
  - Requests are ignored in RESP, so a still-held req is never double-issued.
- Latency: request sampled in IDLE at cycle T gives ready at T+2+RAM_LATENCY. With no competition, back-to-back accesses on one port take 3+RAM_LATENCY cycles each.
- Priority: MEM over IF, because MEM holds the older instruction. IF waits, and stall_req_if stays high while it waits.
- Flush:
  - flush_if during ISSUE, WAIT or RESP of an IF access sets the kill flag.
  - The RAM access still completes and the FSM timing is unchanged.
  - if_ready is not pulsed; the kill flag clears on return to IDLE.
  - flush_if during a MEM access has no effect.
- Stores: ram_we is pulsed with ram_ce; mem_ready follows the same latency; mem_rdata = 0.
- if_rdata and mem_rdata hold their last value outside ready pulses, except mem_rdata = 0 after a store.
- ram_ce and ram_we are 0 in every state except ISSUE.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A 2-bit counter counts consecutive IDLE grants to MEM while if_req is pending.
  - When the counter reaches 3, the next IDLE cycle with if_req grants IF even if mem_req is high.
  - The counter clears on any IF grant or when if_req is low.
- Undefined: strict MEM priority; the counter logic is absent.

Test Plan (RAM_LATENCY = 1, request at cycle 0):
- IF-only read: if_req=1, if_addr=0x100, RAM returns 0x00000013 → ram_ce at cycle 1 with ram_addr=0x100; if_ready=1 with if_rdata=0x00000013 at cycle 3; stall_req_if high on cycles 0-2.
- Simultaneous requests: if_req=1 and mem_req=1 (load at 0x2000, data 0xDEADBEEF) at cycle 0 → mem_ready with 0xDEADBEEF at cycle 3; IF issues ram_ce at cycle 5; if_ready at cycle 7.
- Store: mem_we=1, addr 0x3004, wdata 0x12345678, wmask 0b0011 → ram_ce=ram_we=1 at cycle 1 with those values; mem_ready at cycle 3; mem_rdata=0.
- Flush: IF read granted at cycle 0, flush_if pulsed at cycle 2 → no if_ready at cycle 3; FSM back in IDLE at cycle 4; a new if_req is then serviced normally.
- Reset mid-op: rst asserted asynchronously during WAIT → ram_ce, if_ready, mem_ready drop to 0 immediately; after release, the first request completes with nominal latency.
- MEM_ARB_FAIR_EN: mem_req and if_req held high continuously → grants MEM, MEM, MEM, IF; without the macro, IF is never granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between IF fetch and MEM load/store.
// Optional fairness for IF under sustained MEM traffic: MEM_ARB_FAIR_EN.
module mem_arbiter #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush_if,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  input  logic [31:0] ram_rdata,
  output logic        stall_req_if,
  output logic        stall_req_mem
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  state_t     state;
  logic       owner_mem;
  logic       kill;
  logic       we_q;
  logic [2:0] cnt;

  logic if_ok;
  logic fair_force;
  logic grant_mem;
  logic grant_if;

`ifdef MEM_ARB_FAIR_EN
  logic [1:0] fair_cnt;
  assign fair_force = (fair_cnt == 2'd3);
`else
  assign fair_force = 1'b0;
`endif

  // IDLE grant decision: MEM holds the older instruction, so it wins
  always_comb begin
    if_ok     = if_req & ~flush_if;
    grant_mem = mem_req & ~(if_ok & fair_force);
    grant_if  = if_ok & ~grant_mem;
  end

  // access sequencer: IDLE -> ISSUE -> WAIT x RAM_LATENCY -> RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_mem <= 1'b0;
      kill      <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wmask <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_mem || grant_if) begin
            owner_mem <= grant_mem;
            we_q      <= grant_mem & mem_we;
            ram_addr  <= grant_mem ? mem_addr : if_addr;
            ram_wdata <= grant_mem ? mem_wdata : '0;
            ram_wmask <= grant_mem ? mem_wmask : '0;
            ram_ce    <= 1'b1;
            ram_we    <= grant_mem & mem_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT;
          state <= WAIT;
          if (!owner_mem && flush_if)
            kill <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (!owner_mem && flush_if)
            kill <= 1'b1;
          if (cnt == 3'd1) begin
            state <= RESP;
            if (owner_mem) begin
              mem_ready <= 1'b1;
              mem_rdata <= we_q ? '0 : ram_rdata;
            end else if (!(kill || flush_if)) begin
              if_ready <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end
        end
        RESP: begin
          if (!owner_mem && flush_if)
            kill <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // count MEM grants that overtook a waiting IF; at 3, IF gets a turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_cnt <= '0;
    end else if (!if_req) begin
      fair_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_if)
        fair_cnt <= '0;
      else if (grant_mem && fair_cnt != 2'd3)
        fair_cnt <= fair_cnt + 2'd1;
    end
  end
`endif

  assign stall_req_if  = if_req & ~if_ready;
  assign stall_req_mem = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter, RAM_LATENCY = 1.
// Expected RAM strobes and ready pulses are queued when requests are driven.
module tb_mem_arbiter;

  localparam int unsigned L = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush_if = 1'b0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_rdata = '0;
  logic        stall_req_if;
  logic        stall_req_mem;

  mem_arbiter #(.RAM_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .flush_if(flush_if),
    .if_ready(if_ready),
    .if_rdata(if_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .ram_ce(ram_ce),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask),
    .ram_rdata(ram_rdata),
    .stall_req_if(stall_req_if),
    .stall_req_mem(stall_req_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  wm;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t exp_if[$];
  rsp_t exp_mem[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit free_run = 1'b0;

  logic [31:0] ram [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one cycle read latency, byte-masked writes
  always @(posedge clk) begin
    logic [31:0] old;
    if (ram_ce) begin
      if (ram_we) begin
        old = ram.exists(ram_addr) ? ram[ram_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b])
            old[b*8 +: 8] = ram_wdata[b*8 +: 8];
        ram[ram_addr] = old;
      end else begin
        ram_rdata <= ram.exists(ram_addr) ? ram[ram_addr] : ~ram_addr;
      end
    end
  end

  // scoreboard: compare RAM strobes and ready pulses with the queues
  always @(negedge clk) begin
    iss_t me;
    rsp_t mr;
    if (!rst && !free_run) begin
      if (ram_ce) begin
        if (iss_q.size() == 0) begin
          check("unexp_ce", 1, 0);
        end else begin
          me = iss_q.pop_front();
          check("ce_cyc", cyc, me.cyc);
          check("ram_addr", ram_addr, me.addr);
          check("ram_we", ram_we, me.we);
          if (me.we) begin
            check("ram_wdata", ram_wdata, me.wd);
            check("ram_wmask", ram_wmask, me.wm);
          end
        end
      end else if (ram_we) begin
        check("we_without_ce", 1, 0);
      end
      if (if_ready) begin
        if (exp_if.size() == 0) begin
          check("unexp_if_ready", 1, 0);
        end else begin
          mr = exp_if.pop_front();
          check("if_rdy_cyc", cyc, mr.cyc);
          check("if_rdata", if_rdata, mr.data);
        end
      end
      if (mem_ready) begin
        if (exp_mem.size() == 0) begin
          check("unexp_mem_ready", 1, 0);
        end else begin
          mr = exp_mem.pop_front();
          check("mem_rdy_cyc", cyc, mr.cyc);
          check("mem_rdata", mem_rdata, mr.data);
        end
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if(input bit chk_stall);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_ready)
        got = 1'b1;
      else if (chk_stall)
        check("stall_if", stall_req_if, 1);
    end
    if (!got)
      check("if_timeout", 0, 1);
    else
      check("stall_if_rdy", stall_req_if, 0);
    cyc_start();
    if_req = 1'b0;
  endtask

  task automatic wait_mem(input bit chk_stall);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_ready)
        got = 1'b1;
      else if (chk_stall)
        check("stall_mem", stall_req_mem, 1);
    end
    if (!got)
      check("mem_timeout", 0, 1);
    cyc_start();
    mem_req = 1'b0;
    mem_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] gaddr[$];

    ram[32'h100]  = 32'h0000_0013;
    ram[32'h104]  = 32'h0040_0093;
    ram[32'h2000] = 32'hDEAD_BEEF;
    ram[32'h3004] = 32'hAABB_CCDD;
    ram[32'h300]  = 32'h0020_8133;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    rst = 1'b0;
    repeat (2) cyc_start();

    // IF-only fetch
    k = cyc;
    if_req = 1'b1;
    if_addr = 32'h100;
    iss_q.push_back('{k + 1, 32'h100, 1'b0, 32'h0, 4'h0});
    exp_if.push_back('{k + 3, 32'h0000_0013});
    wait_if(1'b1);

    // simultaneous: MEM first, flush during MEM has no effect
    cyc_start();
    k = cyc;
    if_req = 1'b1;
    if_addr = 32'h104;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h2000;
    iss_q.push_back('{k + 1, 32'h2000, 1'b0, 32'h0, 4'h0});
    iss_q.push_back('{k + 5, 32'h104, 1'b0, 32'h0, 4'h0});
    exp_mem.push_back('{k + 3, 32'hDEAD_BEEF});
    exp_if.push_back('{k + 7, 32'h0040_0093});
    cyc_start();
    cyc_start();
    flush_if = 1'b1;
    fork
      begin
        cyc_start();
        flush_if = 1'b0;
      end
      wait_mem(1'b0);
      wait_if(1'b1);
    join

    // store, then load back the merged word
    cyc_start();
    k = cyc;
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h3004;
    mem_wdata = 32'h1234_5678;
    mem_wmask = 4'b0011;
    iss_q.push_back('{k + 1, 32'h3004, 1'b1, 32'h1234_5678, 4'b0011});
    exp_mem.push_back('{k + 3, 32'h0});
    wait_mem(1'b1);
    @(negedge clk);
    check("store_rdata_hold", mem_rdata, 0);
    cyc_start();
    k = cyc;
    mem_req = 1'b1;
    mem_addr = 32'h3004;
    iss_q.push_back('{k + 1, 32'h3004, 1'b0, 32'h0, 4'h0});
    exp_mem.push_back('{k + 3, 32'hAABB_5678});
    wait_mem(1'b0);

    // flush an IF access in WAIT, then refetch
    cyc_start();
    k = cyc;
    if_req = 1'b1;
    if_addr = 32'h200;
    iss_q.push_back('{k + 1, 32'h200, 1'b0, 32'h0, 4'h0});
    cyc_start();
    cyc_start();
    flush_if = 1'b1;
    cyc_start();
    flush_if = 1'b0;
    if_addr = 32'h300;
    iss_q.push_back('{k + 5, 32'h300, 1'b0, 32'h0, 4'h0});
    exp_if.push_back('{k + 7, 32'h0020_8133});
    @(negedge clk);
    check("flush_no_ready", if_ready, 0);
    wait_if(1'b0);

    // random single-port traffic
    for (int i = 0; i < 8; i++) begin
      cyc_start();
      k = cyc;
      a = 32'h8000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      ram[a] = d;
      if ($urandom_range(0, 1) == 0) begin
        if_req = 1'b1;
        if_addr = a;
        iss_q.push_back('{k + 1, a, 1'b0, 32'h0, 4'h0});
        exp_if.push_back('{k + 3, d});
        wait_if(1'b1);
      end else if ($urandom_range(0, 1) == 0) begin
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = a;
        iss_q.push_back('{k + 1, a, 1'b0, 32'h0, 4'h0});
        exp_mem.push_back('{k + 3, d});
        wait_mem(1'b1);
      end else begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = a;
        mem_wdata = $urandom;
        mem_wmask = 4'($urandom_range(1, 15));
        iss_q.push_back('{k + 1, a, 1'b1, mem_wdata, mem_wmask});
        exp_mem.push_back('{k + 3, 32'h0});
        wait_mem(1'b1);
      end
    end

    // asynchronous reset during WAIT of a load
    cyc_start();
    k = cyc;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h2000;
    iss_q.push_back('{k + 1, 32'h2000, 1'b0, 32'h0, 4'h0});
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_rst_addr", ram_addr, 32'h2000);
    rst = 1'b1;
    #1;
    check("async_ram_ce", ram_ce, 0);
    check("async_ram_addr", ram_addr, 0);
    check("async_mem_ready", mem_ready, 0);
    check("async_if_ready", if_ready, 0);
    mem_req = 1'b0;
    cyc_start();
    rst = 1'b0;
    cyc_start();
    k = cyc;
    if_req = 1'b1;
    if_addr = 32'h100;
    iss_q.push_back('{k + 1, 32'h100, 1'b0, 32'h0, 4'h0});
    exp_if.push_back('{k + 3, 32'h0000_0013});
    wait_if(1'b0);

    // sustained contention: grant order
    cyc_start();
    free_run = 1'b1;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h4000;
    if_req = 1'b1;
    if_addr = 32'h500;
    for (int i = 0; i < 60 && gaddr.size() < 6; i++) begin
      @(negedge clk);
      if (ram_ce)
        gaddr.push_back(ram_addr);
    end
    check("grant_count", gaddr.size(), 6);
    while (gaddr.size() < 6)
      gaddr.push_back(32'hFFFF_FFFF);
`ifdef MEM_ARB_FAIR_EN
    check("grant0", gaddr[0], 32'h4000);
    check("grant1", gaddr[1], 32'h4000);
    check("grant2", gaddr[2], 32'h4000);
    check("grant3", gaddr[3], 32'h500);
    check("grant4", gaddr[4], 32'h4000);
`else
    for (int i = 0; i < 6; i++)
      check($sformatf("grant%0d", i), gaddr[i], 32'h4000);
`endif
    cyc_start();
    mem_req = 1'b0;
    if_req = 1'b0;
    repeat (10) cyc_start();
    free_run = 1'b0;

    check("iss_q_empty", iss_q.size(), 0);
    check("exp_if_empty", exp_if.size(), 0);
    check("exp_mem_empty", exp_mem.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
